// File: rtl/matched_filter_correlator.sv
// Streaming matched-filter correlator.
// Holds one signed fingerprint of CAPTURE_LENGTH entries in a dual-port RAM.
// Accumulates the dot product of each pass of CAPTURE_LENGTH accepted samples
// against that fingerprint, and emits one signed score per pass.
// Valid/ready semantics: there is no ready. Every cycle with axiiv=1 consumes
// axiid. axiov is a one-cycle pulse, and axiod holds its value between pulses.
module matched_filter_correlator #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int MATCH_SCORE_WIDTH = 32,
  parameter int CAPTURE_LENGTH = 1000,
  parameter FINGERPRINT_MEMORY_FILE = ""
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    axiiv,
  input  logic signed [SAMPLE_DATA_WIDTH-1:0]     axiid,
  output logic                                    axiov,
  output logic signed [MATCH_SCORE_WIDTH-1:0]     axiod,
  input  logic [$clog2(CAPTURE_LENGTH)-1:0]       ram_write_addr,
  input  logic signed [SAMPLE_DATA_WIDTH-1:0]     ram_write_data,
  input  logic                                    ram_write_enable
);

  localparam int ADDR_WIDTH = $clog2(CAPTURE_LENGTH);
  localparam int PROD_WIDTH = 2 * SAMPLE_DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(CAPTURE_LENGTH - 1);

  // Fingerprint storage. It powers up all zeros.
  // Reset does not touch it.
  logic signed [SAMPLE_DATA_WIDTH-1:0] mem [0:CAPTURE_LENGTH-1] = '{default: '0};

  logic [ADDR_WIDTH-1:0]               idx;
  logic                                last_now;
  logic signed [SAMPLE_DATA_WIDTH-1:0] rd_d1, rd_d2;
  logic signed [SAMPLE_DATA_WIDTH-1:0] x_d1, x_d2;
  logic                                v_d1, v_d2, l_d1, l_d2;
  logic signed [PROD_WIDTH-1:0]        prod;
  logic                                prod_valid, prod_last;
  logic signed [MATCH_SCORE_WIDTH-1:0] acc;
  logic signed [MATCH_SCORE_WIDTH-1:0] sum;

  assign last_now = axiiv && (idx == LAST_INDEX);
  assign sum      = acc + MATCH_SCORE_WIDTH'(prod);

  // External write port. The nonblocking write means a same-cycle read
  // returns the old word (read-first behaviour).
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_write_addr] <= ram_write_data;
  end

  // Internal read port with two registered stages. The address is the
  // current sample index, read every cycle.
  always_ff @(posedge clk) begin
    rd_d1 <= mem[idx];
    rd_d2 <= rd_d1;
  end

  // Sample index advances once per accepted sample and wraps at the end of a pass.
  always_ff @(posedge clk) begin
    if (rst)        idx <= '0;
    else if (axiiv) idx <= (idx == LAST_INDEX) ? '0 : idx + ADDR_WIDTH'(1);
  end

  // Delay the sample and its valid/last flags by two cycles to line up with the RAM data.
  always_ff @(posedge clk) begin
    x_d1 <= axiid;
    x_d2 <= x_d1;
    if (rst) begin
      v_d1 <= 1'b0;
      v_d2 <= 1'b0;
      l_d1 <= 1'b0;
      l_d2 <= 1'b0;
    end else begin
      v_d1 <= axiiv;
      v_d2 <= v_d1;
      l_d1 <= last_now;
      l_d2 <= l_d1;
    end
  end

  // Register the signed product of the aligned sample and fingerprint entry.
  always_ff @(posedge clk) begin
    prod <= PROD_WIDTH'(x_d2) * PROD_WIDTH'(rd_d2);
    if (rst) begin
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
    end else begin
      prod_valid <= v_d2;
      prod_last  <= l_d2;
    end
  end

  // Accumulate products. On the last product of a pass, publish the score and
  // restart the accumulator from zero, so the next pass starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      axiov <= 1'b0;
      axiod <= '0;
    end else begin
      axiov <= prod_valid && prod_last;
      if (prod_valid) begin
        acc <= prod_last ? '0 : sum;
        if (prod_last) axiod <= sum;
      end
    end
  end

endmodule

// File: tb/tb_matched_filter_correlator.sv
// Directed and randomized bench for matched_filter_correlator with CAPTURE_LENGTH=8.
// The reference model keeps the fingerprint as a plain array. It collects each
// pass's samples in a queue and computes the expected score as a dot product
// when the pass completes. Each expected pulse time is the accept cycle + 4.
module tb_matched_filter_correlator;
  localparam int W  = 8;
  localparam int SW = 32;
  localparam int N  = 8;
  localparam int AW = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 axiiv = 1'b0;
  logic signed [W-1:0]  axiid = '0;
  logic                 axiov;
  logic signed [SW-1:0] axiod;
  logic [AW-1:0]        ram_write_addr = '0;
  logic signed [W-1:0]  ram_write_data = '0;
  logic                 ram_write_enable = 1'b0;

  matched_filter_correlator #(
    .SAMPLE_DATA_WIDTH(W),
    .MATCH_SCORE_WIDTH(SW),
    .CAPTURE_LENGTH(N),
    .FINGERPRINT_MEMORY_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .axiiv(axiiv),
    .axiid(axiid),
    .axiov(axiov),
    .axiod(axiod),
    .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data),
    .ram_write_enable(ram_write_enable)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [SW-1:0]       exp_q[$];
  int                  exp_cyc_q[$];
  logic signed [W-1:0] pass_q[$];
  logic signed [W-1:0] f_model[N];
  logic [SW-1:0]       held = '0;

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  function automatic logic [SW-1:0] model_score();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(pass_q[i]) * int'(f_model[i]);
    return SW'(s);
  endfunction

  // Driver tasks
  task automatic accept(input logic signed [W-1:0] x);
    @(negedge clk);
    ram_write_enable = 1'b0;
    axiiv = 1'b1;
    axiid = x;
    pass_q.push_back(x);
    if (pass_q.size() == N) begin
      exp_q.push_back(model_score());
      exp_cyc_q.push_back(cyc + 4);
      pass_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      axiiv = 1'b0;
      axiid = W'($urandom);
      ram_write_enable = 1'b0;
    end
  endtask

  task automatic write_fp(input int a, input logic signed [W-1:0] d);
    @(negedge clk);
    axiiv = 1'b0;
    ram_write_enable = 1'b1;
    ram_write_addr = AW'(a);
    ram_write_data = d;
    f_model[a] = d;
  endtask

  task automatic load_all(input logic signed [W-1:0] d);
    for (int i = 0; i < N; i++) write_fp(i, d);
    idle(1);
  endtask

  task automatic send_pass(input logic signed [W-1:0] v, input bit gaps);
    for (int i = 0; i < N; i++) begin
      accept(v);
      if (gaps) idle($urandom_range(0, 3));
    end
  endtask

  task automatic drain();
    int guard = 0;
    idle(1);
    while (exp_q.size() != 0 && guard < 40) begin
      idle(1);
      guard++;
    end
    idle(2);
    check("drain_pending_scores", SW'(exp_q.size()), '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    axiiv = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_axiov", SW'(axiov), '0);
      check("reset_axiod", axiod, '0);
    end
    rst = 1'b0;
    pass_q.delete();
    @(negedge clk);
    check("post_reset_axiov", SW'(axiov), '0);
    check("post_reset_axiod", axiod, '0);
  endtask

  // Monitor: checks every score pulse against the scoreboard, and checks
  // that axiod holds between pulses.
  always @(negedge clk) begin
    if (rst) begin
      held = '0;
    end else if (axiov) begin
      if (exp_q.size() == 0) begin
        check("unexpected_axiov", SW'(axiov), '0);
      end else begin
        logic [SW-1:0] e;
        int ec;
        e = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("score", axiod, e);
        check("pulse_cycle", SW'(cyc), SW'(ec));
        held = e;
      end
    end else begin
      check("axiod_hold", axiod, held);
    end
  end

  // Global time limit
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  // Directed steps followed by randomized passes
  initial begin
    for (int i = 0; i < N; i++) f_model[i] = '0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_axiov", SW'(axiov), '0);
      check("reset_axiod", axiod, '0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_axiov", SW'(axiov), '0);
    check("post_reset_axiod", axiod, '0);

    // All ones against all ones gives 8.
    load_all(8'sd1);
    send_pass(8'sd1, 1'b0);
    drain();

    // Alternating signs give -8.
    for (int i = 0; i < N; i++) write_fp(i, (i % 2 == 0) ? 8'sd1 : -8'sd1);
    idle(1);
    for (int i = 0; i < N; i++) accept((i % 2 == 0) ? -8'sd1 : 8'sd1);
    drain();

    // Most negative values with random gaps give 131072.
    load_all(-8'sd128);
    send_pass(-8'sd128, 1'b1);
    drain();

    // Back-to-back passes give 48, then 0, eight cycles apart.
    load_all(8'sd3);
    send_pass(8'sd2, 1'b0);
    send_pass(8'sd0, 1'b0);
    drain();

    // Reset mid-pass aborts that pass. The next full pass scores 8.
    load_all(8'sd1);
    for (int i = 0; i < 5; i++) accept(8'sd1);
    do_reset();
    send_pass(8'sd1, 1'b0);
    drain();

    // Rewriting one entry between passes changes only the later pass: 8, then 12.
    send_pass(8'sd1, 1'b0);
    drain();
    write_fp(3, 8'sd5);
    idle(1);
    send_pass(8'sd1, 1'b0);
    drain();

    // Randomized fingerprints and samples, with optional gaps and back-to-back passes.
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < N; i++) write_fp(i, W'($urandom));
      idle(1);
      repeat ($urandom_range(1, 3)) begin
        for (int i = 0; i < N; i++) begin
          accept(W'($urandom));
          if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
        end
      end
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
